// File: rtl/sram_sync.sv
// sram_sync: synchronous single-port SRAM with active-low pin protocol.
//   DEPTH = 2**ADDR_W words of DATA_W bits, byte-lane write masking,
//   1- or 2-cycle registered read, optional post-reset clear walk.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   chipEnable         active-low select; when high all other controls ignored
//   writeEnable        active-low write strobe (wins over outputEnable)
//   outputEnable       active-low read strobe
//   addr               word address
//   byteEnable         active-high write lanes, bit i -> data_in[8i+7:8i]
//   data_in            write data
//   data_out           read data, holds between reads
//   dataValid          one-cycle pulse when data_out carries new read data
//   ready              high once the block accepts commands
module sram_sync #(
  parameter int                ADDR_W         = 11,
  parameter int                DATA_W         = 8,
  parameter int                READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipEnable,
  input  logic                  writeEnable,
  input  logic                  outputEnable,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   byteEnable,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  dataValid,
  output logic                  ready
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W/8;

  if ((READ_LATENCY != 1 && READ_LATENCY != 2) || (DATA_W % 8) != 0) begin : g_param_err
    $error("sram_sync: READ_LATENCY must be 1 or 2 and DATA_W a multiple of 8");
  end

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clear_addr;
  logic              wr_en, rd_issue;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (&clear_addr) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready is registered so it rises on the edge that finishes the clear
  // (or the first edge out of reset when the clear is skipped); commands
  // are honoured from the following edge on.
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_addr <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= (state_nxt == IDLE);
      if (state == CLEAR) clear_addr <= clear_addr + 1'b1;
    end
  end

  // write has priority over a simultaneous read strobe
  assign wr_en    = ready & ~chipEnable & ~writeEnable;
  assign rd_issue = ready & ~chipEnable &  writeEnable & ~outputEnable;

  // ---------------- storage (never reset) ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clear_addr] <= INIT_VALUE;
      end else if (wr_en) begin
        for (int i = 0; i < LANES; i++)
          if (byteEnable[i]) mem[addr][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  // ---------------- read pipeline ----------------
  // The array is sampled at the issue edge, so a later write to the same
  // address cannot alter a read already in flight.
  if (READ_LATENCY == 2) begin : g_lat2
    logic [2:1]        vld_pipe;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe <= '0;
        rd_data  <= '0;
        data_out <= '0;
      end else begin
        vld_pipe <= {vld_pipe[1], rd_issue};
        if (rd_issue)    rd_data  <= mem[addr];
        if (vld_pipe[1]) data_out <= rd_data;
      end
    end
    assign dataValid = vld_pipe[2];
  end else begin : g_lat1
    logic [1:1] vld_pipe;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe <= '0;
        data_out <= '0;
      end else begin
        vld_pipe[1] <= rd_issue;
        if (rd_issue) data_out <= mem[addr];
      end
    end
    assign dataValid = vld_pipe[1];
  end

endmodule

// File: tb/tb_sram_sync.sv
// Bench for sram_sync: two instances in lockstep (default 2048x8 latency 1,
// and 64x16 latency 2 with a non-zero clear value) against a queue-based model.
module tb_sram_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, we, oe;
  logic [10:0] addr;
  logic [1:0]  be;
  logic [15:0] din;
  logic [7:0]  dout1;
  logic        dv1, rdy1;
  logic [15:0] dout2;
  logic        dv2, rdy2;

  sram_sync u_a (
    .clk(clk), .reset(reset), .chipEnable(ce), .writeEnable(we), .outputEnable(oe),
    .addr(addr), .byteEnable(be[0:0]), .data_in(din[7:0]),
    .data_out(dout1), .dataValid(dv1), .ready(rdy1)
  );

  sram_sync #(.ADDR_W(6), .DATA_W(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1),
              .INIT_VALUE(16'hC3C3)) u_b (
    .clk(clk), .reset(reset), .chipEnable(ce), .writeEnable(we), .outputEnable(oe),
    .addr(addr[5:0]), .byteEnable(be), .data_in(din),
    .data_out(dout2), .dataValid(dv2), .ready(rdy2)
  );

  // ---------------- reference model ----------------
  typedef struct { int d; int due; logic [15:0] data; } rd_t;
  rd_t         pend[$];
  logic [15:0] mm [2][2048];
  bit          m_rdy [2];
  int          m_clr [2];
  logic [15:0] m_dout [2];
  bit          m_dv [2];
  int          cyc_n;
  int          depth [2] = '{2048, 64};
  int          lat   [2] = '{1, 2};
  int          nlane [2] = '{1, 2};
  logic [15:0] initv [2] = '{16'h0000, 16'hC3C3};

  int n_vec = 0;
  int n_err = 0;

  task automatic model_edge();
    cyc_n++;
    for (int d = 0; d < 2; d++) m_dv[d] = 1'b0;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_rdy[d] = 1'b0; m_clr[d] = 0; m_dout[d] = '0;
      end
      pend.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        int a;
        a = (d == 0) ? int'(addr) : int'(addr) % 64;
        if (!m_rdy[d]) begin
          mm[d][m_clr[d]] = initv[d];
          m_clr[d]++;
          if (m_clr[d] == depth[d]) m_rdy[d] = 1'b1;
        end else if (!ce) begin
          if (!we) begin
            for (int i = 0; i < nlane[d]; i++)
              if (be[i]) mm[d][a][8*i +: 8] = din[8*i +: 8];
          end else if (!oe) begin
            rd_t r;
            r.d = d; r.due = cyc_n + lat[d] - 1; r.data = mm[d][a];
            pend.push_back(r);
          end
        end
      end
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due == cyc_n) begin
          m_dv[pend[i].d]   = 1'b1;
          m_dout[pend[i].d] = pend[i].data;
          pend.delete(i);
        end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, cyc_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_rdy1", rdy1, m_rdy[0]);
    chk("m_dv1", dv1, m_dv[0]);
    chk("m_dout1", dout1, m_dout[0][7:0]);
    chk("m_rdy2", rdy2, m_rdy[1]);
    chk("m_dv2", dv2, m_dv[1]);
    chk("m_dout2", dout2, m_dout[1]);
  endtask

  task automatic drive(logic c, logic w, logic o, logic [10:0] a, logic [1:0] b, logic [15:0] dt);
    ce = c; we = w; oe = o; addr = a; be = b; din = dt;
  endtask

  // ---------------- vector table (expectations for u_a, latency 1) ----------------
  typedef struct {
    logic c, w, o; logic [10:0] a; logic [1:0] b; logic [15:0] dt;
    logic ev; logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic w, logic o, logic [10:0] a, logic [1:0] b,
                              logic [15:0] dt, logic ev, logic [7:0] ed);
    vec_t v;
    v.c = c; v.w = w; v.o = o; v.a = a; v.b = b; v.dt = dt; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = 1'b0; m_clr[d] = 0; m_dout[d] = '0; m_dv[d] = 1'b0;
    end
    cyc_n = 0;
    tbl.push_back(mk(0,1,0, 11'd0,    2'b00, 16'h0000, 1, 8'h00));
    tbl.push_back(mk(0,1,0, 11'd2047, 2'b00, 16'h0000, 1, 8'h00));
    tbl.push_back(mk(1,1,1, 11'd0,    2'b00, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0,0,1, 11'd0,    2'b11, 16'hFFFF, 0, 8'h00));
    tbl.push_back(mk(0,1,0, 11'd0,    2'b00, 16'h0000, 1, 8'hFF));
    tbl.push_back(mk(1,1,1, 11'd0,    2'b00, 16'h0000, 0, 8'hFF));
    tbl.push_back(mk(0,1,0, 11'd2047, 2'b00, 16'h0000, 1, 8'h00));
    tbl.push_back(mk(1,1,1, 11'd0,    2'b00, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(1,0,1, 11'd3,    2'b11, 16'hAAAA, 0, 8'h00));
    tbl.push_back(mk(0,1,0, 11'd3,    2'b00, 16'h0000, 1, 8'h00));
    tbl.push_back(mk(1,1,0, 11'd0,    2'b00, 16'h0000, 0, 8'h00));
    tbl.push_back(mk(0,0,1, 11'd5,    2'b11, 16'h5A5A, 0, 8'h00));
    tbl.push_back(mk(0,1,0, 11'd5,    2'b00, 16'h0000, 1, 8'h5A));
    tbl.push_back(mk(0,0,0, 11'd6,    2'b01, 16'h0077, 0, 8'h5A));
    tbl.push_back(mk(0,1,0, 11'd6,    2'b00, 16'h0000, 1, 8'h77));
    tbl.push_back(mk(0,1,0, 11'd0,    2'b00, 16'h0000, 1, 8'hFF));
    tbl.push_back(mk(0,1,0, 11'd5,    2'b00, 16'h0000, 1, 8'h5A));
    tbl.push_back(mk(0,1,0, 11'd6,    2'b00, 16'h0000, 1, 8'h77));
    tbl.push_back(mk(0,1,0, 11'd0,    2'b00, 16'h0000, 1, 8'hFF));
    tbl.push_back(mk(0,0,1, 11'd5,    2'b00, 16'h1111, 0, 8'hFF));
    tbl.push_back(mk(0,1,0, 11'd5,    2'b00, 16'h0000, 1, 8'h5A));
    tbl.push_back(mk(1,1,1, 11'd0,    2'b00, 16'h0000, 0, 8'h5A));

    // reset and clear walk
    reset = 1'b1;
    drive(1, 1, 1, 11'd0, 2'b00, 16'h0000);
    step(); step();
    chk("rst_rdy1", rdy1, 0); chk("rst_dv1", dv1, 0); chk("rst_dout1", dout1, 0);
    chk("rst_rdy2", rdy2, 0); chk("rst_dout2", dout2, 0);
    reset = 1'b0;
    for (int i = 1; i <= 2048; i++) begin
      step();
      if (i == 63)   chk("clr_rdy2_63", rdy2, 0);
      if (i == 64)   chk("clr_rdy2_64", rdy2, 1);
      if (i == 2047) chk("clr_rdy1_2047", rdy1, 0);
      if (i == 2048) chk("clr_rdy1_2048", rdy1, 1);
    end

    // table-driven vectors
    foreach (tbl[k]) begin
      drive(tbl[k].c, tbl[k].w, tbl[k].o, tbl[k].a, tbl[k].b, tbl[k].dt);
      step();
      chk($sformatf("tbl%0d_dv", k), dv1, tbl[k].ev);
      chk($sformatf("tbl%0d_dout", k), dout1, tbl[k].ed);
    end
    step();

    // 16-bit byte masking, latency 2 on u_b
    drive(0, 0, 1, 11'd7, 2'b11, 16'hABCD); step();
    drive(0, 0, 1, 11'd7, 2'b01, 16'h1234); step();
    drive(0, 1, 0, 11'd7, 2'b00, 16'h0000); step();
    chk("be_dv2_early", dv2, 0);
    drive(1, 1, 1, 11'd0, 2'b00, 16'h0000); step();
    chk("be_dv2", dv2, 1); chk("be_dout2", dout2, 16'hAB34);
    // write behind an in-flight read to the same address
    drive(0, 1, 0, 11'd7, 2'b00, 16'h0000); step();
    drive(0, 0, 1, 11'd7, 2'b11, 16'hFFFF); step();
    chk("haz_dv2", dv2, 1); chk("haz_dout2", dout2, 16'hAB34);
    drive(0, 1, 0, 11'd7, 2'b00, 16'h0000); step();
    drive(1, 1, 1, 11'd0, 2'b00, 16'h0000); step();
    chk("haz_new_dout2", dout2, 16'hFFFF);

    // randomized traffic, addresses concentrated to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15)),
            2'($urandom), 16'($urandom));
      step();
    end
    drive(1, 1, 1, 11'd0, 2'b00, 16'h0000); step(); step();

    // reset with a latency-2 read in flight
    drive(0, 1, 0, 11'd7, 2'b00, 16'h0000); step();
    reset = 1'b1; drive(1, 1, 1, 11'd0, 2'b00, 16'h0000); step();
    chk("flush_dv2", dv2, 0); chk("flush_dout2", dout2, 0);
    step();
    chk("flush_dv2_b", dv2, 0);
    reset = 1'b0;

    // reset part-way through the clear restarts it from address 0
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1; step();
    chk("mid_rdy1", rdy1, 0);
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rdy1 && n < 3000);
    chk("reclear_edges", n, 2048);
    drive(0, 1, 0, 11'd0, 2'b00, 16'h0000); step();
    chk("reclear_dv1", dv1, 1); chk("reclear_dout1", dout1, 0);
    drive(1, 1, 1, 11'd0, 2'b00, 16'h0000); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
